// File: rtl/matrix_stream_out.sv
// Streams a snapshot of a (rows-2)x(cols-2) result matrix as valid/ready beats in row-major order.
// Build option: define STREAM_RELU_EN to clamp negative elements to zero on the way out.
module matrix_stream_out #(
    parameter int total_bits = 16,
    parameter int frac_bits  = 8,
    parameter int max_rows   = 8,
    parameter int max_cols   = 8
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               start,
    input  logic [3:0]                                         rows,
    input  logic [3:0]                                         cols,
    input  logic [(max_rows-2)*(max_cols-2)*total_bits-1:0]   matrix_data,
    output logic signed [total_bits-1:0]                       pix_data,
    output logic                                               pix_valid,
    output logic                                               pix_last,
    output logic [3:0]                                         pix_row,
    output logic [3:0]                                         pix_col,
    input  logic                                               pix_ready,
    output logic                                               busy,
    output logic                                               done
);

    // state  | meaning
    // IDLE   | waiting for start, no beat presented
    // SEND   | presenting beat (row_q, col_q) from the snapshot
    // FINISH | one-cycle done pulse, then back to IDLE

    localparam int n_elem = (max_rows - 2) * (max_cols - 2);
    localparam int idx_w  = (n_elem > 1) ? $clog2(n_elem) : 1;
    localparam int snap_w = n_elem * total_bits;

    typedef enum logic [1:0] {IDLE, SEND, FINISH} state_t;

    state_t              state_q, state_d;
    logic [snap_w-1:0]   snap_q, snap_d;
    logic [3:0]          row_q, row_d;
    logic [3:0]          col_q, col_d;
    logic [3:0]          last_row_q, last_row_d;
    logic [3:0]          last_col_q, last_col_d;
    logic [idx_w-1:0]    idx_q, idx_d;

    logic                dims_ok;
    logic                at_last;
    logic [total_bits-1:0] elem;
    logic [total_bits-1:0] beat_word;

    // frac_bits only describes the fixed-point format; data passes through untouched.
    if (frac_bits >= total_bits) begin : g_frac_wider_than_word
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            snap_q     <= '0;
            row_q      <= '0;
            col_q      <= '0;
            last_row_q <= '0;
            last_col_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            snap_q     <= snap_d;
            row_q      <= row_d;
            col_q      <= col_d;
            last_row_q <= last_row_d;
            last_col_q <= last_col_d;
            idx_q      <= idx_d;
        end
    end

    assign dims_ok = (rows >= 4'd3) && (cols >= 4'd3) &&
                     (int'(rows) <= max_rows) && (int'(cols) <= max_cols);
    assign at_last = (row_q == last_row_q) && (col_q == last_col_q);

    // Linear index equals r*(cols-2)+c because beats advance in row-major order.
    always_comb begin
        elem = '0;
        for (int i = 0; i < n_elem; i++) begin
            if (idx_q == idx_w'(i)) begin
                elem = snap_q[i*total_bits +: total_bits];
            end
        end
    end

    always_comb begin
`ifdef STREAM_RELU_EN
        beat_word = elem[total_bits-1] ? '0 : elem;
`else
        beat_word = elem;
`endif
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        row_d      = row_q;
        col_d      = col_q;
        last_row_d = last_row_q;
        last_col_d = last_col_q;
        idx_d      = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (dims_ok) begin
                        snap_d     = matrix_data;
                        last_row_d = rows - 4'd3;
                        last_col_d = cols - 4'd3;
                        row_d      = '0;
                        col_d      = '0;
                        idx_d      = '0;
                        state_d    = SEND;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            SEND: begin
                if (pix_ready) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = FINISH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == last_col_q) begin
                            col_d = '0;
                            row_d = row_q + 4'd1;
                        end else begin
                            col_d = col_q + 4'd1;
                        end
                    end
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pix_valid = (state_q == SEND);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FINISH);
    assign pix_last  = pix_valid && at_last;
    assign pix_row   = pix_valid ? row_q : 4'd0;
    assign pix_col   = pix_valid ? col_q : 4'd0;
    assign pix_data  = pix_valid ? beat_word : '0;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Randomized self-checking bench for matrix_stream_out against a queue-based beat model.
// Honours STREAM_RELU_EN the same way the design does.
module tb_matrix_stream_out;

    localparam int TB = 16;
    localparam int MW = 6 * 6 * TB;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  r;
        logic [3:0]  c;
        logic        l;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        rows = 4'd0;
    logic [3:0]        cols = 4'd0;
    logic [MW-1:0]     matrix_data = '0;
    logic signed [15:0] pix_data;
    logic              pix_valid;
    logic              pix_last;
    logic [3:0]        pix_row;
    logic [3:0]        pix_col;
    logic              pix_ready = 1'b0;
    logic              busy;
    logic              done;

    int tests = 0;
    int fails = 0;
    int ready_mode = 3;
    int done_pending = 0;
    beat_t exp_q[$];
    bit exp_next_valid = 0;
    bit exp_next_done = 0;

    matrix_stream_out dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rows(rows), .cols(cols),
        .matrix_data(matrix_data), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_last(pix_last), .pix_row(pix_row), .pix_col(pix_col),
        .pix_ready(pix_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic beat_q_t build(input int r, input int c, input logic [MW-1:0] md);
        beat_q_t q;
        logic [15:0] w;
        int k;
        q = {};
        if (r >= 3 && r <= 8 && c >= 3 && c <= 8) begin
            for (int i = 0; i < r - 2; i++) begin
                for (int j = 0; j < c - 2; j++) begin
                    k = i * (c - 2) + j;
                    w = md[k*16 +: 16];
`ifdef STREAM_RELU_EN
                    if (w[15]) w = 16'h0000;
`endif
                    q.push_back('{w, 4'(i), 4'(j), (i == r - 3) && (j == c - 3)});
                end
            end
        end
        return q;
    endfunction

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: pix_ready = 1'b1;
            1: pix_ready = ~pix_ready;
            2: pix_ready = 1'($urandom_range(0, 1));
            default: pix_ready = 1'b0;
        endcase
    end

    // Single compare process: every cycle, outputs versus the expected beat queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk(!pix_valid && !busy && !done && !pix_last && pix_data == 0 && pix_row == 0 && pix_col == 0,
                "reset_outputs", {pix_valid, busy, done, pix_last}, 0);
            exp_next_valid = 0;
            exp_next_done = 0;
        end else begin
            if (exp_next_valid) chk(pix_valid, "no_bubble", pix_valid, 1);
            if (exp_next_done) chk(done && !pix_valid, "done_after_last", {done, pix_valid}, 2'b10);
            exp_next_valid = 0;
            exp_next_done = 0;
            if (pix_valid) begin
                chk(busy, "busy_when_valid", busy, 1);
                if (exp_q.size() == 0) begin
                    chk(0, "extra_beat", {pix_row, pix_col}, 0);
                end else begin
                    chk(pix_data == exp_q[0].d, "beat_data", pix_data, exp_q[0].d);
                    chk(pix_row == exp_q[0].r && pix_col == exp_q[0].c, "beat_coord",
                        {pix_row, pix_col}, {exp_q[0].r, exp_q[0].c});
                    chk(pix_last == exp_q[0].l, "beat_last", pix_last, exp_q[0].l);
                    if (pix_ready) begin
                        if (exp_q[0].l) exp_next_done = 1;
                        else exp_next_valid = 1;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk(pix_data == 0 && pix_row == 0 && pix_col == 0 && !pix_last, "idle_zero",
                    {pix_data, pix_row, pix_col, pix_last}, 0);
            end
            if (done) begin
                chk(done_pending > 0, "done_expected", done_pending, 1);
                chk(exp_q.size() == 0, "done_early", exp_q.size(), 0);
                chk(busy, "busy_in_finish", busy, 1);
                if (done_pending > 0) done_pending--;
            end
        end
    end

    task automatic start_txn(input int r, input int c);
        beat_q_t q;
        bit ok_dims;
        ok_dims = (r >= 3 && r <= 8 && c >= 3 && c <= 8);
        rows = 4'(r);
        cols = 4'(c);
        q = build(r, c, matrix_data);
        foreach (q[i]) exp_q.push_back(q[i]);
        done_pending = 1;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        if (ok_dims) chk(pix_valid && busy, "latency1", {pix_valid, busy}, 2'b11);
        else chk(done && !pix_valid, "bad_dims_done", {done, pix_valid}, 2'b10);
    endtask

    task automatic wait_idle(input bit noisy);
        int i;
        for (i = 0; i < 400; i++) begin
            if (done_pending == 0) break;
            if (noisy && busy && $urandom_range(0, 9) == 0) begin
                for (int w = 0; w < MW / 32; w++) matrix_data[w*32 +: 32] = $urandom;
                rows = 4'($urandom_range(3, 8));
                cols = 4'($urandom_range(3, 8));
                start = 1'b1;
                cyc(1);
                start = 1'b0;
            end else begin
                cyc(1);
            end
        end
        chk(done_pending == 0, "done_timeout", done_pending, 0);
        chk(!busy, "idle_after_done", busy, 0);
    endtask

    task automatic fill_rand();
        for (int w = 0; w < MW / 32; w++) matrix_data[w*32 +: 32] = $urandom;
    endtask

    initial begin
        beat_q_t pin;
        logic [MW-1:0] md;

        #2;
        chk(!pix_valid && !busy && !done, "reset_state", {pix_valid, busy, done}, 0);
        #10 rst_n = 1'b1;
        cyc(2);

        // Model pins.
        md = '0;
        for (int k = 0; k < 9; k++) md[k*16 +: 16] = 16'(k * 256);
        pin = build(5, 5, md);
        chk(pin.size() == 9, "pin_count_5x5", pin.size(), 9);
        chk(pin[8].d == 16'h0800 && pin[8].l && pin[8].r == 2 && pin[8].c == 2, "pin_last_5x5",
            {pin[8].d, pin[8].r, pin[8].c}, {16'h0800, 4'd2, 4'd2});
        chk(pin[3].r == 1 && pin[3].c == 0 && !pin[3].l, "pin_order", {pin[3].r, pin[3].c}, 8'h10);
        chk(build(8, 8, md).size() == 36 && build(2, 6, md).size() == 0, "pin_dims", 0, 0);
        md[15:0] = 16'hFF00;
        pin = build(5, 5, md);
`ifdef STREAM_RELU_EN
        chk(pin[0].d == 16'h0000, "pin_relu", pin[0].d, 16'h0000);
`else
        chk(pin[0].d == 16'hFF00, "pin_passthru", pin[0].d, 16'hFF00);
`endif

        // 5x5 ramp with ready held high: consecutive literal beats.
        ready_mode = 0;
        cyc(1);
        matrix_data = '0;
        for (int k = 0; k < 9; k++) matrix_data[k*16 +: 16] = 16'(k * 256);
        start_txn(5, 5);
        for (int k = 0; k < 9; k++) begin
            chk(pix_valid && pix_data == 16'(k * 256) && pix_row == 4'(k / 3) && pix_col == 4'(k % 3)
                && pix_last == (k == 8), "ramp_beat", {pix_valid, pix_data}, {1'b1, 16'(k * 256)});
            cyc(1);
        end
        chk(done && !pix_valid, "ramp_done", {done, pix_valid}, 2'b10);
        wait_idle(0);

        // 8x8 with toggling ready.
        ready_mode = 1;
        fill_rand();
        start_txn(8, 8);
        wait_idle(0);

        // Out-of-range dimensions.
        ready_mode = 0;
        start_txn(2, 6);
        wait_idle(0);

        // Negative element (0,0).
        fill_rand();
        matrix_data[15:0] = 16'hFF00;
        start_txn(3, 3);
`ifdef STREAM_RELU_EN
        chk(pix_data == 16'sh0000, "relu_out", pix_data, 16'h0000);
`else
        chk(pix_data == 16'shFF00, "passthru_out", pix_data, 16'hFF00);
`endif
        wait_idle(0);

        // Reset after four beats, then restart from (0,0).
        matrix_data = '0;
        for (int k = 0; k < 9; k++) matrix_data[k*16 +: 16] = 16'(k * 256);
        start_txn(5, 5);
        cyc(4);
        rst_n = 1'b0;
        exp_q.delete();
        done_pending = 0;
        #1;
        chk(!pix_valid && !busy && !done, "reset_midstream", {pix_valid, busy, done}, 0);
        #10 rst_n = 1'b1;
        cyc(5);
        chk(!busy, "no_restart_without_start", busy, 0);
        start_txn(5, 5);
        chk(pix_row == 0 && pix_col == 0 && pix_data == 0, "restart_origin", {pix_row, pix_col}, 0);
        wait_idle(0);

        // Mid-stream start with new data is ignored.
        fill_rand();
        start_txn(6, 7);
        cyc(3);
        fill_rand();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        wait_idle(0);

        // Randomized transactions.
        for (int t = 0; t < 30; t++) begin
            ready_mode = $urandom_range(0, 2);
            fill_rand();
            start_txn($urandom_range(2, 9), $urandom_range(2, 9));
            wait_idle(1);
            cyc($urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
